// File: rtl/dram_cmd_frontend.sv
// Host command front end: in-order command FIFO with read-after-write hazard detection and statistics.
// Define DRAM_CMD_FWD_EN to answer hazard reads locally instead of stalling the host.
module dram_cmd_frontend #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 26,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_rw,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [DATA_W-1:0] i_cmd_wdata,
   output logic              o_issue_valid,
   input  logic              i_issue_ready,
   output logic              o_issue_rw,
   output logic [ADDR_W-1:0] o_issue_addr,
   output logic [DATA_W-1:0] o_issue_wdata,
   output logic              o_fwd_valid,
   output logic [DATA_W-1:0] o_fwd_data,
   output logic [CNT_W-1:0]  o_wr_count,
   output logic [CNT_W-1:0]  o_rd_count,
   output logic [CNT_W-1:0]  o_raw_count
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {RUN, STALL} state_e;
   state_e state_q, state_d;

   logic [AW:0]       wr_ptr_q, rd_ptr_q, count;
   logic              mem_rw_q   [DEPTH];
   logic [ADDR_W-1:0] mem_addr_q [DEPTH];
   logic [DATA_W-1:0] mem_data_q [DEPTH];

   logic full, empty, hit, hazard, accept, enq, deq, raw_inc;
   logic [AW-1:0] idx;
`ifdef DRAM_CMD_FWD_EN
   logic [DATA_W-1:0] hit_data;
   logic              fwd_valid_q;
   logic [DATA_W-1:0] fwd_data_q;
`endif

   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // Scan oldest to youngest over the pre-dequeue contents so the last match is the youngest write
   always_comb begin
      hit = 1'b0;
      idx = '0;
`ifdef DRAM_CMD_FWD_EN
      hit_data = '0;
`endif
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q[AW-1:0] + AW'(k);
         if (k < 32'(count) && mem_rw_q[idx] && mem_addr_q[idx] == i_cmd_addr) begin
            hit = 1'b1;
`ifdef DRAM_CMD_FWD_EN
            hit_data = mem_data_q[idx];
`endif
         end
      end
   end

   assign hazard = i_cmd_valid && !i_cmd_rw && hit;
   assign accept = i_cmd_valid && o_cmd_ready;
   assign deq    = o_issue_valid && i_issue_ready;

`ifdef DRAM_CMD_FWD_EN
   assign o_cmd_ready = !full && (state_q == RUN);
   assign enq         = accept && !hazard;
   assign raw_inc     = accept && hazard;
   assign o_fwd_valid = fwd_valid_q;
   assign o_fwd_data  = fwd_data_q;

   always_comb begin
      state_d = RUN;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fwd_valid_q <= 1'b0;
         fwd_data_q  <= '0;
      end else begin
         fwd_valid_q <= accept && hazard;
         if (accept && hazard) fwd_data_q <= hit_data;
      end
   end
`else
   // Ready drops combinationally on a hazard; once the matching write has left, the held read
   // is accepted in the same cycle the FSM returns to RUN.
   assign o_cmd_ready = !full && !hazard;
   assign enq         = accept;
   assign raw_inc     = (state_q == RUN) && hazard;
   assign o_fwd_valid = 1'b0;
   assign o_fwd_data  = '0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (hazard)  state_d = STALL;
         STALL:   if (!hazard) state_d = RUN;
         default: state_d = RUN;
      endcase
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= RUN;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         o_wr_count  <= '0;
         o_rd_count  <= '0;
         o_raw_count <= '0;
      end else begin
         state_q <= state_d;
         if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (accept && i_cmd_rw && o_wr_count != '1)   o_wr_count  <= o_wr_count + 1'b1;
         if (accept && !i_cmd_rw && o_rd_count != '1)  o_rd_count  <= o_rd_count + 1'b1;
         if (raw_inc && o_raw_count != '1)             o_raw_count <= o_raw_count + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (enq) begin
         mem_rw_q[wr_ptr_q[AW-1:0]]   <= i_cmd_rw;
         mem_addr_q[wr_ptr_q[AW-1:0]] <= i_cmd_addr;
         mem_data_q[wr_ptr_q[AW-1:0]] <= i_cmd_wdata;
      end
   end

   assign o_issue_valid = !empty;
   assign o_issue_rw    = mem_rw_q[rd_ptr_q[AW-1:0]];
   assign o_issue_addr  = mem_addr_q[rd_ptr_q[AW-1:0]];
   assign o_issue_wdata = mem_data_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_dram_cmd_frontend.sv
// Directed self-checking bench for dram_cmd_frontend (default build stalls on hazards;
// define DRAM_CMD_FWD_EN on both to exercise the forwarding path).
module tb_dram_cmd_frontend;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned ADDR_W = 26;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid, cmd_ready, cmd_rw;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              issue_valid, issue_ready, issue_rw;
   logic [ADDR_W-1:0] issue_addr;
   logic [DATA_W-1:0] issue_wdata;
   logic              fwd_valid;
   logic [DATA_W-1:0] fwd_data;
   logic [CNT_W-1:0]  wr_count, rd_count, raw_count;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [ADDR_W-1:0] q[$];

   dram_cmd_frontend #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rw(cmd_rw),
      .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
      .o_issue_valid(issue_valid), .i_issue_ready(issue_ready), .o_issue_rw(issue_rw),
      .o_issue_addr(issue_addr), .o_issue_wdata(issue_wdata),
      .o_fwd_valid(fwd_valid), .o_fwd_data(fwd_data),
      .o_wr_count(wr_count), .o_rd_count(rd_count), .o_raw_count(raw_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = a;
      cmd_wdata = d;
      #1;
      chk("push_ready", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      q.push_back(a);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      issue_ready = 1'b0;
      tick();
      chk("rst_issue_valid", 64'(issue_valid), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_wr_count", 64'(wr_count), 64'd0);
      chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
      chk("rst_fwd_data", fwd_data, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // three writes with the scheduler blocked
      push(1'b1, 26'h10, 64'h1);
      push(1'b1, 26'h20, 64'h2);
      push(1'b1, 26'h30, 64'h3);
      chk("t1_wr_count", 64'(wr_count), 64'd3);
      chk("t1_head_valid", 64'(issue_valid), 64'd1);
      chk("t1_head_addr", 64'(issue_addr), 64'h10);
      chk("t1_head_rw", 64'(issue_rw), 64'd1);
      chk("t1_head_wdata", issue_wdata, 64'h1);

      // fill to DEPTH, then one dequeue while full
      for (int i = 0; i < 5; i++) push(1'b1, 26'h50 + 26'(i), 64'h50 + 64'(i));
      #1;
      chk("t2_full_ready", 64'(cmd_ready), 64'd0);
      issue_ready = 1'b1;
      #1;
      chk("t2_no_bypass", 64'(cmd_ready), 64'd0);
      tick();
      issue_ready = 1'b0;
      void'(q.pop_front());
      #1;
      chk("t2_ready_after_deq", 64'(cmd_ready), 64'd1);
      chk("t2_head_after_deq", 64'(issue_addr), 64'(q[0]));

      // simultaneous enqueue/dequeue pairs, pointers wrap several times
      for (int i = 0; i < 20; i++) begin
         cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 26'h100 + 26'(i); cmd_wdata = 64'(i);
         issue_ready = 1'b1;
         #1;
         chk("t2_pair_head", 64'(issue_addr), 64'(q[0]));
         tick();
         void'(q.pop_front());
         q.push_back(26'h100 + 26'(i));
      end
      cmd_valid = 1'b0; issue_ready = 1'b0;
      #1;
      chk("t2_wr_count", 64'(wr_count), 64'd28);
      for (int i = 0; i < 7; i++) begin
         issue_ready = 1'b1;
         #1;
         chk("t2_drain_head", 64'(issue_addr), 64'(q[0]));
         tick();
         void'(q.pop_front());
      end
      issue_ready = 1'b0;
      #1;
      chk("t2_empty", 64'(issue_valid), 64'd0);

`ifdef DRAM_CMD_FWD_EN
      // youngest matching write is forwarded, read never reaches the issue port
      push(1'b1, 26'h40, 64'hAA);
      push(1'b1, 26'h40, 64'hBB);
      push(1'b0, 26'h40, 64'h0);
      chk("t3_fwd_valid", 64'(fwd_valid), 64'd1);
      chk("t3_fwd_data", fwd_data, 64'hBB);
      chk("t3_raw_count", 64'(raw_count), 64'd1);
      chk("t3_rd_count", 64'(rd_count), 64'd1);
      chk("t3_head_rw", 64'(issue_rw), 64'd1);
      tick();
      chk("t3_fwd_pulse", 64'(fwd_valid), 64'd0);
      // read against a write leaving this cycle still forwards
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 26'h40; issue_ready = 1'b1;
      tick();
      cmd_valid = 1'b0; issue_ready = 1'b0;
      chk("t5_fwd_data", fwd_data, 64'hBB);
      chk("t5_raw_count", 64'(raw_count), 64'd2);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      q.delete();
      chk("t5_wr_count", 64'(wr_count), 64'd30);
`else
      // hazard read stalls the host until the write issues; counted once
      push(1'b1, 26'h40, 64'hAA);
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 26'h40;
      #1;
      chk("t4_stall_ready", 64'(cmd_ready), 64'd0);
      tick(); tick(); tick();
      chk("t4_raw_once", 64'(raw_count), 64'd1);
      chk("t4_rd_held", 64'(rd_count), 64'd0);
      issue_ready = 1'b1;
      #1;
      chk("t4_deq_still_stall", 64'(cmd_ready), 64'd0);
      tick();
      issue_ready = 1'b0;
      #1;
      chk("t4_release_ready", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      chk("t4_rd_count", 64'(rd_count), 64'd1);
      chk("t4_raw_still1", 64'(raw_count), 64'd1);
      chk("t4_head_rw", 64'(issue_rw), 64'd0);
      chk("t4_head_addr", 64'(issue_addr), 64'h40);
      chk("t4_fwd_tied", 64'(fwd_valid), 64'd0);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;

      // read arrives in the cycle the matching write dequeues
      push(1'b1, 26'h44, 64'hCC);
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 26'h44; issue_ready = 1'b1;
      #1;
      chk("t5_ready", 64'(cmd_ready), 64'd0);
      tick();
      issue_ready = 1'b0;
      chk("t5_raw_count", 64'(raw_count), 64'd2);
      tick();
      cmd_valid = 1'b0;
      chk("t5_rd_count", 64'(rd_count), 64'd2);
      chk("t5_head_addr", 64'(issue_addr), 64'h44);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      q.delete();
      chk("t5_wr_count", 64'(wr_count), 64'd30);
`endif

      // asynchronous reset with five entries queued
      for (int i = 0; i < 5; i++) push(1'b1, 26'h200 + 26'(i), 64'(i));
      chk("t6_pre_valid", 64'(issue_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_issue_valid", 64'(issue_valid), 64'd0);
      chk("t6_wr_count", 64'(wr_count), 64'd0);
      chk("t6_rd_count", 64'(rd_count), 64'd0);
      chk("t6_raw_count", 64'(raw_count), 64'd0);
      chk("t6_ready", 64'(cmd_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_post_empty", 64'(issue_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
